// File: rtl/tl_pkg.sv
// Shared types and helpers for the N-way traffic-light phase controller.
// Lamp codes, controller states and the round-robin next-way search.
package tl_pkg;

   typedef enum logic [1:0] {
      L_RED    = 2'd0,
      L_YELLOW = 2'd1,
      L_GREEN  = 2'd2
   } lamp_t;

   typedef enum logic [1:0] {
      ST_GREEN,
      ST_YELLOW,
      ST_ALLRED
   } state_t;

   localparam int MAX_WAY = 8;

   // First demanding way after cur, wrapping at n; cur when none.
   function automatic logic [2:0] rr_next(
      input logic [7:0] dem,
      input logic [3:0] n,
      input logic [2:0] cur
   );
      logic [3:0] idx;
      logic       found;
      rr_next = cur;
      found   = 1'b0;
      for (int k = 1; k < MAX_WAY; k++) begin
         idx = {1'b0, cur} + 4'(k);
         if (idx >= n) idx = idx - n;
         if (4'(k) < n && !found && dem[idx[2:0]]) begin
            rr_next = idx[2:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: next demanding way after cur and
// a flag saying whether any way other than cur has demand.
module tl_rr_pick
   import tl_pkg::*;
#(
   parameter  int N_WAY = 4,
   localparam int WW    = $clog2(N_WAY)
) (
   input  logic [N_WAY-1:0] demand,
   input  logic [WW-1:0]    cur,
   input  logic             en,
   output logic [WW-1:0]    next,
   output logic             other
);

   logic [7:0]       dem8;
   logic [2:0]       cur3;
   logic [2:0]       pick;
   logic [N_WAY-1:0] msk;

   always_comb begin
      dem8                = '0;
      dem8[N_WAY-1:0]     = demand;
      cur3                = '0;
      cur3[WW-1:0]        = cur;
      pick                = rr_next(dem8, 4'(N_WAY), cur3);
      msk                 = demand;
      msk[cur]            = 1'b0;
      next                = en ? pick[WW-1:0] : cur;
      other               = en & (|msk);
   end

endmodule

// File: rtl/tl_phase_ctrl.sv
// N-way round-robin traffic-light phase controller (green/yellow/all-red).
// Optional emergency preemption ports enabled by defining TL_PREEMPT_EN.
module tl_phase_ctrl
   import tl_pkg::*;
#(
   parameter  int N_WAY     = 4,
   parameter  int MIN_GREEN = 8,
   parameter  int MAX_GREEN = 32,
   parameter  int YELLOW_T  = 4,
   parameter  int ALLRED_T  = 2,
   localparam int WW        = $clog2(N_WAY),
   localparam int CW        = $clog2(MAX_GREEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_WAY-1:0]   car_present,
`ifdef TL_PREEMPT_EN
   input  logic               preempt_req,
   input  logic [WW-1:0]      preempt_way,
`endif
   output logic [2*N_WAY-1:0] light,
   output logic [WW-1:0]      active_way,
   output logic               phase_change,
   output logic [CW-1:0]      phase_timer
);

   localparam logic [2*N_WAY-1:0] LIGHT_RST =
      {{(2*N_WAY-2){1'b0}}, L_GREEN};

   state_t             state, state_d;
   logic [CW-1:0]      timer_d;
   logic [WW-1:0]      act_d, nxt, nxt_d, pick;
   logic               pc_d, other, leave, go_green;
   logic               pre_hold, pre_go;
   logic [WW-1:0]      pre_way;
   logic [2*N_WAY-1:0] light_d;

   tl_rr_pick #(.N_WAY(N_WAY)) u_pick (
      .demand (car_present),
      .cur    (active_way),
      .en     (state == ST_GREEN),
      .next   (pick),
      .other  (other)
   );

`ifdef TL_PREEMPT_EN
   assign pre_way  = preempt_way;
   assign pre_hold = preempt_req && (active_way == preempt_way);
   assign pre_go   = preempt_req && (active_way != preempt_way);
`else
   assign pre_way  = '0;
   assign pre_hold = 1'b0;
   assign pre_go   = 1'b0;
`endif

   always_comb begin
      state_d  = state;
      timer_d  = phase_timer;
      act_d    = active_way;
      nxt_d    = nxt;
      pc_d     = 1'b0;
      leave    = 1'b0;
      go_green = 1'b0;
      unique case (state)
         ST_GREEN: begin
            if (phase_timer != CW'(MAX_GREEN - 1))
               timer_d = phase_timer + 1'b1;
            leave = other
                 && phase_timer >= CW'(MIN_GREEN - 1)
                 && (!car_present[active_way]
                     || phase_timer == CW'(MAX_GREEN - 1));
            if (pre_hold) leave = 1'b0;
            if (pre_go)   leave = 1'b1;
            if (leave) begin
               state_d = ST_YELLOW;
               timer_d = '0;
               nxt_d   = pre_go ? pre_way : pick;
            end
         end
         ST_YELLOW: begin
            timer_d = phase_timer + 1'b1;
            if (phase_timer == CW'(YELLOW_T - 1)) begin
               timer_d = '0;
               if (ALLRED_T == 0) go_green = 1'b1;
               else               state_d  = ST_ALLRED;
            end
         end
         ST_ALLRED: begin
            timer_d = phase_timer + 1'b1;
            if (phase_timer == CW'(ALLRED_T - 1)) go_green = 1'b1;
         end
         default: state_d = ST_GREEN;
      endcase
      // A request seen during clearance overrides the latched way.
      if (go_green) begin
         state_d = ST_GREEN;
         timer_d = '0;
         pc_d    = 1'b1;
         act_d   = (pre_go || pre_hold) ? pre_way : nxt;
      end
      light_d = '0;
      for (int i = 0; i < N_WAY; i++) begin
         if (act_d == WW'(i)) begin
            if (state_d == ST_GREEN)  light_d[2*i +: 2] = L_GREEN;
            if (state_d == ST_YELLOW) light_d[2*i +: 2] = L_YELLOW;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_GREEN;
         phase_timer  <= '0;
         active_way   <= '0;
         nxt          <= '0;
         phase_change <= 1'b0;
         light        <= LIGHT_RST;
      end else begin
         state        <= state_d;
         phase_timer  <= timer_d;
         active_way   <= act_d;
         nxt          <= nxt_d;
         phase_change <= pc_d;
         light        <= light_d;
      end
   end

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Scoreboard bench for tl_phase_ctrl with default parameters.
// Preemption scenario runs only when TL_PREEMPT_EN is defined.
module tb_tl_phase_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] car_present = '0;
   logic [7:0] light;
   logic [1:0] active_way;
   logic       phase_change;
   logic [5:0] phase_timer;
`ifdef TL_PREEMPT_EN
   logic       preempt_req = 1'b0;
   logic [1:0] preempt_way = '0;
`endif

   tl_phase_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .car_present  (car_present),
`ifdef TL_PREEMPT_EN
      .preempt_req  (preempt_req),
      .preempt_way  (preempt_way),
`endif
      .light        (light),
      .active_way   (active_way),
      .phase_change (phase_change),
      .phase_timer  (phase_timer)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [7:0] light;
      logic [1:0] way;
      logic       pc;
      logic [5:0] tmr;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] lv(input int way, input logic [1:0] code);
      lv = '0;
      lv[2*way +: 2] = code;
   endfunction

   task automatic push(input string tag, input logic [7:0] l,
                       input int way, input logic pc, input int t);
      exp_t e;
      e.tag = tag; e.light = l; e.way = 2'(way); e.pc = pc; e.tmr = 6'(t);
      q.push_back(e);
   endtask

   task automatic push_green(input string tag, input int way, input int n,
                             input int t0, input logic pc_first);
      for (int i = 0; i < n; i++)
         push(tag, lv(way, 2'd2), way, pc_first && i == 0,
              (t0 + i > 31) ? 31 : t0 + i);
   endtask

   task automatic push_clear(input string tag, input int way);
      for (int i = 0; i < 4; i++) push({tag, "_y"}, lv(way, 2'd1), way, 1'b0, i);
      for (int i = 0; i < 2; i++) push({tag, "_ar"}, 8'h00, way, 1'b0, i);
   endtask

   task automatic step();
      exp_t e;
      int   lit;
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = q.pop_front();
      chk({e.tag, "_light"}, 32'(light), 32'(e.light));
      chk({e.tag, "_way"},   32'(active_way), 32'(e.way));
      chk({e.tag, "_pc"},    32'(phase_change), 32'(e.pc));
      chk({e.tag, "_tmr"},   32'(phase_timer), 32'(e.tmr));
      lit = 0;
      for (int i = 0; i < 4; i++) if (light[2*i +: 2] != 2'd0) lit++;
      chk({e.tag, "_onelit"}, 32'(lit <= 1), 32'd1);
   endtask

   task automatic drain();
      int budget = 500;
      while (q.size() > 0 && budget > 0) begin
         step();
         budget--;
      end
      if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   // Reset edge is observed as cycle 0 (way0 green, timer 0).
   task automatic do_reset(input logic [3:0] cars);
      reset = 1'b1;
      car_present = cars;
      push("rst", lv(0, 2'd2), 0, 1'b0, 0);
      step();
      reset = 1'b0;
   endtask

   initial begin
      // Single side demand: 8 green, 4 yellow, 2 all-red, way1 green.
      do_reset(4'b0010);
      push_green("t1g0", 0, 7, 1, 1'b0);
      push_clear("t1", 0);
      push_green("t1g1", 1, 4, 0, 1'b1);
      drain();

      // Both demanding: way0 held to MAX_GREEN.
      do_reset(4'b0011);
      push_green("t2g0", 0, 31, 1, 1'b0);
      push_clear("t2", 0);
      push_green("t2g1", 1, 3, 0, 1'b1);
      drain();

      // No demand: hold and saturate.
      do_reset(4'b0000);
      push_green("t3", 0, 99, 1, 1'b0);
      drain();

      // Wrap from way3 to way0.
      do_reset(4'b1000);
      push_green("t4g0", 0, 7, 1, 1'b0);
      push_clear("t4a", 0);
      push_green("t4g3", 3, 2, 0, 1'b1);
      drain();
      car_present = 4'b1001;
      push_green("t4g3b", 3, 30, 2, 1'b0);
      push_clear("t4b", 3);
      push_green("t4w0", 0, 2, 0, 1'b1);
      drain();

      // From way2 with 0101: way3 skipped, way0 chosen.
      do_reset(4'b0100);
      push_green("t5g0", 0, 7, 1, 1'b0);
      push_clear("t5a", 0);
      push_green("t5g2", 2, 2, 0, 1'b1);
      drain();
      car_present = 4'b0101;
      push_green("t5g2b", 2, 30, 2, 1'b0);
      push_clear("t5b", 2);
      push_green("t5w0", 0, 2, 0, 1'b1);
      drain();

      // Reset during yellow returns straight to way0 green.
      do_reset(4'b0010);
      push_green("t6g0", 0, 7, 1, 1'b0);
      push("t6y", lv(0, 2'd1), 0, 1'b0, 0);
      push("t6y", lv(0, 2'd1), 0, 1'b0, 1);
      drain();
      do_reset(4'b0010);
      push_green("t6post", 0, 3, 1, 1'b0);
      drain();

`ifdef TL_PREEMPT_EN
      do_reset(4'b0010);
      push_green("p_g0", 0, 7, 1, 1'b0);
      push_clear("p_a", 0);
      push_green("p_g1", 1, 3, 0, 1'b1);
      drain();
      preempt_req = 1'b1;
      preempt_way = 2'd3;
      car_present = 4'b0111;
      push_clear("p_b", 1);
      push_green("p_g3", 3, 40, 0, 1'b1);
      drain();
      preempt_req = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
